// File: rtl/bcedn_unpool.sv
// Max-unpooling stage for the BCEDN decoder: pooled rows are buffered in two
// ping-pong banks and each is expanded to POOL_H rows of W*POOL_W pixels.
module bcedn_unpool #(
  parameter int H            = 2,
  parameter int W            = 4,
  parameter int FD           = 8,
  parameter int POOL_H       = 2,
  parameter int POOL_W       = 2,
  parameter int PINDEX_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_en,
  input  logic [FD-1:0]           data_in,
  input  logic [PINDEX_WIDTH-1:0] pindex_in,
  output logic                    in_rdy,
  output logic                    out_en,
  output logic [FD-1:0]           data_out,
  output logic                    frame_done,
  output logic                    err_ovf,
  output logic [1:0]              dbg_state
);

  localparam int OW  = W * POOL_W;
  localparam int CW  = (W > 1) ? $clog2(W) : 1;
  localparam int OCW = (OW > 1) ? $clog2(OW) : 1;
  localparam int PHW = (POOL_H > 1) ? $clog2(POOL_H) : 1;
  localparam int RW  = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CW-1:0]    wr_col_q, wr_col_d;
  logic [PHW-1:0]   ph_q, ph_d;
  logic [OCW-1:0]   oc_q, oc_d;
  logic [RW-1:0]    row_q, row_d;
  logic             out_en_q, out_en_d;
  logic [FD-1:0]    data_out_q, data_out_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;

  logic [FD-1:0]           bank_data_q [2][W];
  logic [PINDEX_WIDTH-1:0] bank_pidx_q [2][W];

  logic          wr_fire;
  logic          col_last, oc_last, ph_last, row_last;
  logic [CW-1:0] src_col;
  int            win_pos;
  logic          win_hit;

  // Input handshake: a pixel transfers when in_en and in_rdy are both 1 on a
  // rising edge; in_en with in_rdy low drops the pixel and sets sticky err_ovf.
  // The output side has no back-pressure: out_en qualifies data_out each cycle.
  assign in_rdy  = ~full_q[wr_bank_q];
  assign wr_fire = in_en & in_rdy & ~start;

  assign col_last = (wr_col_q == CW'(W - 1));
  assign oc_last  = (oc_q == OCW'(OW - 1));
  assign ph_last  = (ph_q == PHW'(POOL_H - 1));
  assign row_last = (row_q == RW'(H - 1));

  // Window positions at or above POOL_H*POOL_W are unreachable, so such
  // pindex values never hit and the whole window emits zeros.
  assign src_col = CW'(int'(oc_q) / POOL_W);
  assign win_pos = int'(ph_q) * POOL_W + int'(oc_q) % POOL_W;
  assign win_hit = (int'(bank_pidx_q[rd_bank_q][src_col]) == win_pos);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_data_q[wr_bank_q][wr_col_q] <= data_in;
      bank_pidx_q[wr_bank_q][wr_col_q] <= pindex_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_col_d     = wr_col_q;
    ph_d         = ph_q;
    oc_d         = oc_q;
    row_d        = row_q;
    out_en_d     = 1'b0;
    data_out_d   = '0;
    frame_done_d = (state_q == S_DONE);
    err_d        = err_q | (in_en & ~in_rdy);

    if (wr_fire) begin
      if (col_last) begin
        wr_col_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = S_EMIT;
          ph_d    = '0;
          oc_d    = '0;
        end
      end
      S_EMIT: begin
        out_en_d   = 1'b1;
        data_out_d = win_hit ? bank_data_q[rd_bank_q][src_col] : '0;
        if (oc_last) begin
          oc_d = '0;
          if (ph_last) begin
            ph_d              = '0;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            if (row_last) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + 1'b1;
              // Staying in EMIT when the other bank is ready keeps rows gapless.
              if (!full_q[~rd_bank_q]) state_d = S_IDLE;
            end
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end else begin
          oc_d = oc_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      state_q      <= S_IDLE;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_col_q     <= '0;
      ph_q         <= '0;
      oc_q         <= '0;
      row_q        <= '0;
      out_en_q     <= 1'b0;
      data_out_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_col_q     <= wr_col_d;
      ph_q         <= ph_d;
      oc_q         <= oc_d;
      row_q        <= row_d;
      out_en_q     <= out_en_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign out_en     = out_en_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;
  assign err_ovf    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bcedn_unpool.sv
// Bench for bcedn_unpool: an unpool reference model fills an expected queue
// that a negedge monitor drains, plus per-scenario timing checks.
module tb_bcedn_unpool;

  localparam int H       = 2;
  localparam int W       = 4;
  localparam int FD      = 8;
  localparam int POOL_H  = 2;
  localparam int POOL_W  = 2;
  localparam int PIW     = 2;
  localparam int ROW_OUT = POOL_H * W * POOL_W;

  logic           clk, rst, start, in_en;
  logic [FD-1:0]  data_in;
  logic [PIW-1:0] pindex_in;
  logic           in_rdy, out_en, frame_done, err_ovf;
  logic [FD-1:0]  data_out;
  logic [1:0]     dbg_state;

  int n_cmp   = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  int out_cnt = 0;
  int nz_cnt  = 0;

  logic [FD-1:0]  exp_q[$];
  logic [FD-1:0]  row_d[W];
  logic [PIW-1:0] row_p[W];
  int             row_fill = 0;
  logic [FD-1:0]  mon_exp;

  bcedn_unpool #(
    .H(H), .W(W), .FD(FD), .POOL_H(POOL_H), .POOL_W(POOL_W), .PINDEX_WIDTH(PIW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_en(in_en),
    .data_in(data_in), .pindex_in(pindex_in), .in_rdy(in_rdy),
    .out_en(out_en), .data_out(data_out), .frame_done(frame_done),
    .err_ovf(err_ovf), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required bench to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clk_step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; in_en = 1'b0;
    repeat (2) clk_step();
    rst = 1'b0;
    exp_q.delete();
    row_fill = 0;
  endtask

  task automatic start_pulse;
    start = 1'b1; in_en = 1'b0;
    clk_step();
    start = 1'b0;
    exp_q.delete();
    row_fill = 0;
  endtask

  // ---------------- reference model ----------------
  // Each output pixel takes its window's stored value when the window
  // position r*POOL_W + (c mod POOL_W) equals the stored argmax, else zero.
  function automatic void model_accept(input logic [FD-1:0] d, input logic [PIW-1:0] p);
    row_d[row_fill] = d;
    row_p[row_fill] = p;
    row_fill++;
    if (row_fill == W) begin
      for (int r = 0; r < POOL_H; r++) begin
        for (int c = 0; c < W * POOL_W; c++) begin
          int src;
          int win;
          src = c / POOL_W;
          win = r * POOL_W + c % POOL_W;
          exp_q.push_back((int'(row_p[src]) == win) ? row_d[src] : '0);
        end
      end
      row_fill = 0;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic send_pixel(input logic [FD-1:0] d, input logic [PIW-1:0] p);
    n_cmp++;
    if (in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL send_rdy: in_rdy=%b, required 1", in_rdy);
    end
    model_accept(d, p);
    in_en = 1'b1; data_in = d; pindex_in = p;
    clk_step();
    in_en = 1'b0;
  endtask

  task automatic drain(output bit ok);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) clk_step();
    ok = (exp_q.size() == 0);
    repeat (3) clk_step();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_en === 1'b1) begin
        out_cnt++;
        if (data_out != '0) nz_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: out_en=1 data_out=%h, required no output", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_out !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_data: data_out=%h, required %h", data_out, mon_exp);
          end
        end
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset();
    n_cmp += 5;
    if (out_en !== 1'b0) begin n_fail++; $display("FAIL rst_out_en: %b, required 0", out_en); end
    if (data_out !== '0) begin n_fail++; $display("FAIL rst_data_out: %h, required 00", data_out); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: %b, required 0", frame_done); end
    if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_err_ovf: %b, required 0", err_ovf); end
    if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_in_rdy: %b, required 1", in_rdy); end
  endtask

  task automatic test_basic_row;
    logic [FD-1:0] tbl [ROW_OUT];
    int  fd0;
    bit  ok;
    tbl = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 8'h44};
    fd0 = fd_cnt;
    send_pixel(8'h11, 2'd0);
    send_pixel(8'h22, 2'd1);
    send_pixel(8'h33, 2'd2);
    send_pixel(8'h44, 2'd3);
    n_cmp++;
    if (out_en !== 1'b0) begin n_fail++; $display("FAIL lat_edge0: out_en=%b, required 0", out_en); end
    clk_step();
    n_cmp++;
    if (out_en !== 1'b0) begin n_fail++; $display("FAIL lat_edge1: out_en=%b, required 0", out_en); end
    clk_step();
    for (int k = 0; k < ROW_OUT; k++) begin
      n_cmp++;
      if (out_en !== 1'b1 || data_out !== tbl[k]) begin
        n_fail++;
        $display("FAIL basic_pix%0d: out_en=%b data_out=%h, required 1/%h", k, out_en, data_out, tbl[k]);
      end
      clk_step();
    end
    n_cmp++;
    if (out_en !== 1'b0) begin n_fail++; $display("FAIL basic_end: out_en=%b, required 0", out_en); end
    for (int i = 0; i < W; i++) send_pixel(FD'($urandom), PIW'($urandom_range(0, 3)));
    drain(ok);
    n_cmp += 3;
    if (!ok) begin n_fail++; $display("FAIL basic_drain: %0d left, required 0", exp_q.size()); end
    if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL basic_fd: %0d pulses, required 1", fd_cnt - fd0); end
    if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_err: %b, required 0", err_ovf); end
  endtask

  task automatic test_back_to_back;
    int fd0, run, best, runs;
    bit prev, fd_seen, fd_ok;
    fd0 = fd_cnt; run = 0; best = 0; runs = 0;
    prev = 1'b0; fd_seen = 1'b0; fd_ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i < 2 * W) begin
        in_en = 1'b1; data_in = FD'($urandom); pindex_in = PIW'($urandom_range(0, 3));
        n_cmp++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy%0d: %b, required 1", i, in_rdy); end
        model_accept(data_in, pindex_in);
      end else begin
        in_en = 1'b0;
      end
      clk_step();
      if (out_en === 1'b1) begin
        if (!prev) runs++;
        run = prev ? run + 1 : 1;
        if (run > best) best = run;
      end
      if (frame_done === 1'b1 && !fd_seen) begin
        fd_seen = 1'b1;
        fd_ok = prev && (out_en === 1'b0);
      end
      prev = (out_en === 1'b1);
    end
    in_en = 1'b0;
    n_cmp += 6;
    if (runs != 1) begin n_fail++; $display("FAIL b2b_runs: %0d runs, required 1", runs); end
    if (best != 2 * ROW_OUT) begin n_fail++; $display("FAIL b2b_len: %0d, required %0d", best, 2 * ROW_OUT); end
    if (!(fd_seen && fd_ok)) begin n_fail++; $display("FAIL b2b_fd_pos: seen=%b after_last=%b, required 1/1", fd_seen, fd_ok); end
    if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL b2b_fd: %0d pulses, required 1", fd_cnt - fd0); end
    if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_err: %b, required 0", err_ovf); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d left, required 0", exp_q.size()); end
  endtask

  // Bank 0 fills at edge 4 and is released at edge 21 (one IDLE->EMIT cycle plus
  // 16 pixels); bank 1 fills at edge 8, so pixels 8..20 meet a full bank.
  task automatic test_overflow;
    int  fd0;
    bit  exp_rdy, ok;
    start_pulse();
    fd0 = fd_cnt;
    for (int i = 0; i < 25; i++) begin
      exp_rdy = !(i >= 8 && i <= 20);
      in_en = 1'b1; data_in = FD'($urandom); pindex_in = PIW'($urandom_range(0, 3));
      n_cmp += 2;
      if (in_rdy !== exp_rdy) begin n_fail++; $display("FAIL ovf_rdy%0d: %b, required %b", i, in_rdy, exp_rdy); end
      if (err_ovf !== (i >= 9)) begin n_fail++; $display("FAIL ovf_err%0d: %b, required %b", i, err_ovf, (i >= 9)); end
      if (exp_rdy) model_accept(data_in, pindex_in);
      clk_step();
    end
    in_en = 1'b0;
    drain(ok);
    n_cmp += 3;
    if (!ok) begin n_fail++; $display("FAIL ovf_drain: %0d left, required 0", exp_q.size()); end
    if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL ovf_fd: %0d pulses, required 1", fd_cnt - fd0); end
    if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: %b, required 1", err_ovf); end
  endtask

  task automatic test_reset_mid_emit;
    int  fd0, oc0, w;
    bit  ok;
    start_pulse();
    fd0 = fd_cnt;
    for (int i = 0; i < W; i++) send_pixel(FD'($urandom), PIW'($urandom_range(0, 3)));
    w = 0;
    while (out_en !== 1'b1 && w < 10) begin clk_step(); w++; end
    n_cmp++;
    if (out_en !== 1'b1) begin n_fail++; $display("FAIL rme_start: out_en=%b, required 1", out_en); end
    repeat (3) clk_step();
    rst = 1'b1;
    clk_step();
    n_cmp += 3;
    if (out_en !== 1'b0) begin n_fail++; $display("FAIL rme_out_en: %b, required 0", out_en); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rme_fd: %b, required 0", frame_done); end
    if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rme_rdy: %b, required 1", in_rdy); end
    rst = 1'b0;
    exp_q.delete();
    row_fill = 0;
    oc0 = out_cnt;
    repeat (20) clk_step();
    n_cmp += 2;
    if (out_cnt != oc0) begin n_fail++; $display("FAIL rme_quiet: %0d outputs, required 0", out_cnt - oc0); end
    if (fd_cnt != fd0) begin n_fail++; $display("FAIL rme_nofd: %0d pulses, required 0", fd_cnt - fd0); end
    for (int i = 0; i < H * W; i++) send_pixel(FD'($urandom), PIW'($urandom_range(0, 3)));
    drain(ok);
    n_cmp += 3;
    if (!ok) begin n_fail++; $display("FAIL rme_drain: %0d left, required 0", exp_q.size()); end
    if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL rme_fd_after: %0d pulses, required 1", fd_cnt - fd0); end
    if (out_cnt - oc0 != H * ROW_OUT) begin n_fail++; $display("FAIL rme_count: %0d, required %0d", out_cnt - oc0, H * ROW_OUT); end
  endtask

  task automatic test_pindex3;
    int fd0, oc0, nz0;
    bit ok;
    start_pulse();
    fd0 = fd_cnt; oc0 = out_cnt; nz0 = nz_cnt;
    for (int i = 0; i < H * W; i++) send_pixel(8'hFF, 2'd3);
    drain(ok);
    n_cmp += 4;
    if (!ok) begin n_fail++; $display("FAIL p3_drain: %0d left, required 0", exp_q.size()); end
    if (nz_cnt - nz0 != H * W) begin n_fail++; $display("FAIL p3_nonzero: %0d, required %0d", nz_cnt - nz0, H * W); end
    if (out_cnt - oc0 != H * ROW_OUT) begin n_fail++; $display("FAIL p3_count: %0d, required %0d", out_cnt - oc0, H * ROW_OUT); end
    if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL p3_fd: %0d pulses, required 1", fd_cnt - fd0); end
  endtask

  task automatic test_start_mid_row;
    int fd0;
    bit ok;
    start_pulse();
    send_pixel(8'hAA, 2'd0);
    send_pixel(8'hBB, 2'd1);
    start = 1'b1; in_en = 1'b1; data_in = 8'hEE; pindex_in = 2'd2;
    clk_step();
    start = 1'b0; in_en = 1'b0;
    exp_q.delete();
    row_fill = 0;
    fd0 = fd_cnt;
    n_cmp += 2;
    if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL smr_err: %b, required 0", err_ovf); end
    if (out_en !== 1'b0) begin n_fail++; $display("FAIL smr_out_en: %b, required 0", out_en); end
    for (int i = 0; i < H * W; i++) send_pixel(FD'($urandom_range(1, 255)), PIW'($urandom_range(0, 3)));
    drain(ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("FAIL smr_drain: %0d left, required 0", exp_q.size()); end
    if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL smr_fd: %0d pulses, required 1", fd_cnt - fd0); end
  endtask

  task automatic test_random;
    int fd0;
    bit ok;
    start_pulse();
    fd0 = fd_cnt;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < H * W; i++) begin
        repeat ($urandom_range(0, 3)) clk_step();
        for (int w = 0; w < 64 && in_rdy !== 1'b1; w++) clk_step();
        send_pixel(FD'($urandom), PIW'($urandom_range(0, 3)));
      end
    end
    drain(ok);
    n_cmp += 3;
    if (!ok) begin n_fail++; $display("FAIL rnd_drain: %0d left, required 0", exp_q.size()); end
    if (fd_cnt - fd0 != 4) begin n_fail++; $display("FAIL rnd_fd: %0d pulses, required 4", fd_cnt - fd0); end
    if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL rnd_err: %b, required 0", err_ovf); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in_en = 1'b0; data_in = '0; pindex_in = '0;
    test_reset();
    test_basic_row();
    test_back_to_back();
    test_overflow();
    test_reset_mid_emit();
    test_pindex3();
    test_start_mid_row();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue: %0d left, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
